// File: rtl/tcp_msg_poller_pkg.sv
// Shared types and system widths for the TCP message poller request path.
// The three system widths mirror the platform-wide values used elsewhere in the poller.
package tcp_msg_poller_pkg;

  localparam int FLOWID_W        = 4;
  localparam int XY_WIDTH        = 8;
  localparam int NOC_FBITS_WIDTH = 4;
  localparam int MSG_REQ_LEN_W   = 16;

  typedef struct packed {
    logic [MSG_REQ_LEN_W-1:0]   length;
    logic [XY_WIDTH-1:0]        dst_x;
    logic [XY_WIDTH-1:0]        dst_y;
    logic [NOC_FBITS_WIDTH-1:0] dst_fbits;
  } msg_req_mem_struct;

  typedef enum logic [1:0] {
    REQ_OK       = 2'd0,
    REQ_DUP      = 2'd1,
    REQ_ZERO_LEN = 2'd2
  } msg_req_status_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_WR_MEM = 3'd2,
    ST_WR_Q   = 3'd3,
    ST_RESP   = 3'd4
  } registrar_state_e;

endpackage

// File: rtl/tcp_msg_req_registrar_bitvec.sv
// Per-flow "poll active" bits with a popcount-style counter; the read port
// hides a same-cycle clear so a request racing the poller's clear sees the flow idle.
module tcp_msg_active_bitvec
  import tcp_msg_poller_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_val,
  input  logic [FLOWID_W-1:0] set_flowid,
  input  logic                clear_val,
  input  logic [FLOWID_W-1:0] clear_flowid,
  input  logic [FLOWID_W-1:0] rd_flowid,
  output logic                rd_active,
  output logic [FLOWID_W:0]   active_cnt
);

  localparam int NUM_FLOWS = 1 << FLOWID_W;

  logic [NUM_FLOWS-1:0] bits_r;
  logic [NUM_FLOWS-1:0] bits_nxt_s;
  logic [FLOWID_W:0]    cnt_r;
  logic [FLOWID_W:0]    cnt_nxt_s;
  logic                 set_eff_s;
  logic                 clr_eff_s;

  // Next bit array and count; a set on the same flow as a clear wins and is not counted as a clear
  always_comb begin
    set_eff_s  = set_val & ~bits_r[set_flowid];
    clr_eff_s  = clear_val & bits_r[clear_flowid] & ~(set_val & (set_flowid == clear_flowid));
    bits_nxt_s = bits_r;
    bits_nxt_s[clear_flowid] = bits_r[clear_flowid] & ~clr_eff_s;
    bits_nxt_s[set_flowid]   = bits_nxt_s[set_flowid] | set_val;
    cnt_nxt_s  = cnt_r + {{FLOWID_W{1'b0}}, set_eff_s} - {{FLOWID_W{1'b0}}, clr_eff_s};
  end

  // State update for bits and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_r <= {NUM_FLOWS{1'b0}};
      cnt_r  <= {(FLOWID_W+1){1'b0}};
    end else begin
      bits_r <= bits_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign rd_active  = bits_r[rd_flowid] & ~(clear_val & (clear_flowid == rd_flowid));
  assign active_cnt = cnt_r;

endmodule

// File: rtl/tcp_msg_req_registrar.sv
// Accepts app message requests, records them in the msg-request memory, then
// enqueues the flowid for the poller and reports OK / DUP / ZERO_LEN.
module tcp_msg_req_registrar
  import tcp_msg_poller_pkg::*;
#(
  parameter int POLLER_PTR_W = MSG_REQ_LEN_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       app_msg_req_val,
  output logic                       app_msg_req_rdy,
  input  logic [FLOWID_W-1:0]        app_msg_req_flowid,
  input  logic [POLLER_PTR_W-1:0]    app_msg_req_len,
  input  logic [XY_WIDTH-1:0]        app_msg_req_dst_x,
  input  logic [XY_WIDTH-1:0]        app_msg_req_dst_y,
  input  logic [NOC_FBITS_WIDTH-1:0] app_msg_req_dst_fbits,
  output logic                       msg_req_resp_val,
  input  logic                       msg_req_resp_rdy,
  output logic [FLOWID_W-1:0]        msg_req_resp_flowid,
  output logic [1:0]                 msg_req_resp_status,
  output logic                       reg_msg_req_mem_wr_val,
  input  logic                       reg_msg_req_mem_wr_rdy,
  output logic [FLOWID_W-1:0]        reg_msg_req_mem_wr_addr,
  output msg_req_mem_struct          reg_msg_req_mem_wr_data,
  output logic                       reg_msg_req_q_wr_val,
  input  logic                       reg_msg_req_q_wr_rdy,
  output logic [FLOWID_W-1:0]        reg_msg_req_q_wr_data,
  input  logic                       poll_active_bitvec_clear_req_val,
  input  logic [FLOWID_W-1:0]        poll_active_bitvec_clear_req_flowid,
  output logic [FLOWID_W:0]          active_flow_cnt
);

  registrar_state_e           state_r;
  msg_req_status_e            status_r;
  logic [FLOWID_W-1:0]        req_flowid_r;
  logic [POLLER_PTR_W-1:0]    req_len_r;
  logic [XY_WIDTH-1:0]        req_dst_x_r;
  logic [XY_WIDTH-1:0]        req_dst_y_r;
  logic [NOC_FBITS_WIDTH-1:0] req_dst_fbits_r;
  logic                       rdy_r;
  logic                       mem_val_r;
  logic                       q_val_r;
  logic                       resp_val_r;
  logic                       set_val_s;
  logic                       active_s;

  assign set_val_s = q_val_r & reg_msg_req_q_wr_rdy;

  tcp_msg_active_bitvec u_bitvec (
    .clk          (clk),
    .rst          (rst),
    .set_val      (set_val_s),
    .set_flowid   (req_flowid_r),
    .clear_val    (poll_active_bitvec_clear_req_val),
    .clear_flowid (poll_active_bitvec_clear_req_flowid),
    .rd_flowid    (req_flowid_r),
    .rd_active    (active_s),
    .active_cnt   (active_flow_cnt)
  );

  // Request FSM; every handshake output is a register updated on the state transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      status_r        <= REQ_OK;
      req_flowid_r    <= {FLOWID_W{1'b0}};
      req_len_r       <= {POLLER_PTR_W{1'b0}};
      req_dst_x_r     <= {XY_WIDTH{1'b0}};
      req_dst_y_r     <= {XY_WIDTH{1'b0}};
      req_dst_fbits_r <= {NOC_FBITS_WIDTH{1'b0}};
      rdy_r           <= 1'b0;
      mem_val_r       <= 1'b0;
      q_val_r         <= 1'b0;
      resp_val_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (app_msg_req_val && rdy_r) begin
            req_flowid_r    <= app_msg_req_flowid;
            req_len_r       <= app_msg_req_len;
            req_dst_x_r     <= app_msg_req_dst_x;
            req_dst_y_r     <= app_msg_req_dst_y;
            req_dst_fbits_r <= app_msg_req_dst_fbits;
            rdy_r           <= 1'b0;
            state_r         <= ST_CHECK;
          end else begin
            rdy_r <= 1'b1;
          end
        end
        ST_CHECK: begin
          // Zero length is reported ahead of a duplicate
          if (req_len_r == {POLLER_PTR_W{1'b0}}) begin
            status_r   <= REQ_ZERO_LEN;
            resp_val_r <= 1'b1;
            state_r    <= ST_RESP;
          end else if (active_s) begin
            status_r   <= REQ_DUP;
            resp_val_r <= 1'b1;
            state_r    <= ST_RESP;
          end else begin
            status_r   <= REQ_OK;
            mem_val_r  <= 1'b1;
            state_r    <= ST_WR_MEM;
          end
        end
        ST_WR_MEM: begin
          if (reg_msg_req_mem_wr_rdy) begin
            mem_val_r <= 1'b0;
            q_val_r   <= 1'b1;
            state_r   <= ST_WR_Q;
          end
        end
        ST_WR_Q: begin
          if (reg_msg_req_q_wr_rdy) begin
            q_val_r    <= 1'b0;
            resp_val_r <= 1'b1;
            state_r    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (msg_req_resp_rdy) begin
            resp_val_r <= 1'b0;
            rdy_r      <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          rdy_r      <= 1'b0;
          mem_val_r  <= 1'b0;
          q_val_r    <= 1'b0;
          resp_val_r <= 1'b0;
        end
      endcase
    end
  end

  assign app_msg_req_rdy         = rdy_r;
  assign msg_req_resp_val        = resp_val_r;
  assign msg_req_resp_flowid     = req_flowid_r;
  assign msg_req_resp_status     = status_r;
  assign reg_msg_req_mem_wr_val  = mem_val_r;
  assign reg_msg_req_mem_wr_addr = req_flowid_r;
  assign reg_msg_req_mem_wr_data = {req_len_r, req_dst_x_r, req_dst_y_r, req_dst_fbits_r};
  assign reg_msg_req_q_wr_val    = q_val_r;
  assign reg_msg_req_q_wr_data   = req_flowid_r;

endmodule

// File: tb/tb_tcp_msg_req_registrar.sv
// Self-checking bench: directed vector table, reset corner, then random requests
// against a cycle-event model of the active-flow set.
module tb_tcp_msg_req_registrar;
  import tcp_msg_poller_pkg::*;

  localparam int NF = 1 << FLOWID_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic app_msg_req_val = 1'b0;
  logic app_msg_req_rdy;
  logic [FLOWID_W-1:0] app_msg_req_flowid = '0;
  logic [15:0] app_msg_req_len = '0;
  logic [XY_WIDTH-1:0] app_msg_req_dst_x = '0;
  logic [XY_WIDTH-1:0] app_msg_req_dst_y = '0;
  logic [NOC_FBITS_WIDTH-1:0] app_msg_req_dst_fbits = '0;
  logic msg_req_resp_val;
  logic msg_req_resp_rdy = 1'b0;
  logic [FLOWID_W-1:0] msg_req_resp_flowid;
  logic [1:0] msg_req_resp_status;
  logic reg_msg_req_mem_wr_val;
  logic reg_msg_req_mem_wr_rdy = 1'b0;
  logic [FLOWID_W-1:0] reg_msg_req_mem_wr_addr;
  msg_req_mem_struct reg_msg_req_mem_wr_data;
  logic reg_msg_req_q_wr_val;
  logic reg_msg_req_q_wr_rdy = 1'b0;
  logic [FLOWID_W-1:0] reg_msg_req_q_wr_data;
  logic poll_active_bitvec_clear_req_val = 1'b0;
  logic [FLOWID_W-1:0] poll_active_bitvec_clear_req_flowid = '0;
  logic [FLOWID_W:0] active_flow_cnt;

  tcp_msg_req_registrar dut (
    .clk(clk), .rst(rst),
    .app_msg_req_val(app_msg_req_val), .app_msg_req_rdy(app_msg_req_rdy),
    .app_msg_req_flowid(app_msg_req_flowid), .app_msg_req_len(app_msg_req_len),
    .app_msg_req_dst_x(app_msg_req_dst_x), .app_msg_req_dst_y(app_msg_req_dst_y),
    .app_msg_req_dst_fbits(app_msg_req_dst_fbits),
    .msg_req_resp_val(msg_req_resp_val), .msg_req_resp_rdy(msg_req_resp_rdy),
    .msg_req_resp_flowid(msg_req_resp_flowid), .msg_req_resp_status(msg_req_resp_status),
    .reg_msg_req_mem_wr_val(reg_msg_req_mem_wr_val), .reg_msg_req_mem_wr_rdy(reg_msg_req_mem_wr_rdy),
    .reg_msg_req_mem_wr_addr(reg_msg_req_mem_wr_addr), .reg_msg_req_mem_wr_data(reg_msg_req_mem_wr_data),
    .reg_msg_req_q_wr_val(reg_msg_req_q_wr_val), .reg_msg_req_q_wr_rdy(reg_msg_req_q_wr_rdy),
    .reg_msg_req_q_wr_data(reg_msg_req_q_wr_data),
    .poll_active_bitvec_clear_req_val(poll_active_bitvec_clear_req_val),
    .poll_active_bitvec_clear_req_flowid(poll_active_bitvec_clear_req_flowid),
    .active_flow_cnt(active_flow_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit model_active [NF];

  typedef struct {
    logic [FLOWID_W-1:0] f;
    logic [15:0] len;
    logic [7:0] x, y;
    logic [3:0] fb;
    int ms, qs, clr_cyc;
    logic [FLOWID_W-1:0] cf;
    int exp_st;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < NF; i++) n += model_active[i] ? 1 : 0;
    return n;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One request; exp_st < 0 means take the expectation from the model's rules
  task automatic run_req(input logic [FLOWID_W-1:0] f, input logic [15:0] len,
                         input logic [7:0] x, input logic [7:0] y, input logic [3:0] fb,
                         input int ms, input int qs, input int clr_cyc,
                         input logic [FLOWID_W-1:0] cf, input int exp_st, input string tag);
    int exp = 0, lat = 0, set_cyc = -1, resp_cyc = -1;
    int mseen = 0, qseen = 0, mem_wr = 0, q_wr = 0;
    bit mem_done = 0, done = 0, bad_data = 0, bad_order = 0, bad_rdy = 0;
    logic [1:0] got_st = 2'd0;
    logic [FLOWID_W-1:0] got_f = '0;
    logic [35:0] exp_data = {len, x, y, fb};
    for (int i = 0; i < 8 && !app_msg_req_rdy; i++) step();
    chk({tag, "_rdy"}, app_msg_req_rdy, 1);
    app_msg_req_val = 1'b1; app_msg_req_flowid = f; app_msg_req_len = len;
    app_msg_req_dst_x = x; app_msg_req_dst_y = y; app_msg_req_dst_fbits = fb;
    msg_req_resp_rdy = 1'b1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc == 1) begin
        if (len == 16'd0) exp = 2;
        else if (model_active[f] && !(clr_cyc == 1 && cf == f)) exp = 1;
        else exp = 0;
        if (exp_st >= 0) exp = exp_st;
        set_cyc = (exp == 0) ? 3 + ms + qs : -1;
        lat     = (exp == 0) ? 4 + ms + qs : 2;
        if (app_msg_req_rdy !== 1'b0) bad_rdy = 1;
      end
      poll_active_bitvec_clear_req_val = (cyc == clr_cyc);
      poll_active_bitvec_clear_req_flowid = cf;
      reg_msg_req_mem_wr_rdy = reg_msg_req_mem_wr_val && (mseen >= ms);
      reg_msg_req_q_wr_rdy   = reg_msg_req_q_wr_val && (qseen >= qs);
      if (reg_msg_req_mem_wr_val === 1'b1) begin
        if (reg_msg_req_mem_wr_addr !== f || reg_msg_req_mem_wr_data !== exp_data) bad_data = 1;
        mseen++;
        if (reg_msg_req_mem_wr_rdy) begin mem_done = 1; mem_wr++; end
      end
      if (reg_msg_req_q_wr_val === 1'b1) begin
        if (!mem_done) bad_order = 1;
        if (reg_msg_req_q_wr_data !== f) bad_data = 1;
        qseen++;
        if (reg_msg_req_q_wr_rdy) q_wr++;
      end
      if (msg_req_resp_val === 1'b1) begin
        resp_cyc = cyc; got_st = msg_req_resp_status; got_f = msg_req_resp_flowid; done = 1;
      end
      step();
      if (cyc == 0) app_msg_req_val = 1'b0;
      if (cyc == clr_cyc && !(cyc == set_cyc && cf == f)) model_active[cf] = 0;
      if (cyc == set_cyc) model_active[f] = 1;
    end
    poll_active_bitvec_clear_req_val = 1'b0;
    reg_msg_req_mem_wr_rdy = 1'b0;
    reg_msg_req_q_wr_rdy = 1'b0;
    chk({tag, "_resp_seen"}, done, 1);
    chk({tag, "_latency"}, resp_cyc, lat);
    chk({tag, "_status"}, got_st, exp);
    chk({tag, "_resp_flowid"}, got_f, f);
    chk({tag, "_mem_writes"}, mem_wr, (exp == 0) ? 1 : 0);
    chk({tag, "_q_writes"}, q_wr, (exp == 0) ? 1 : 0);
    chk({tag, "_wr_data_stable"}, bad_data, 0);
    chk({tag, "_q_after_mem"}, bad_order, 0);
    chk({tag, "_rdy_low_busy"}, bad_rdy, 0);
    chk({tag, "_cnt"}, active_flow_cnt, model_cnt());
  endtask

  task automatic clear_pulse(input logic [FLOWID_W-1:0] cf, input string tag);
    poll_active_bitvec_clear_req_val = 1'b1;
    poll_active_bitvec_clear_req_flowid = cf;
    step();
    poll_active_bitvec_clear_req_val = 1'b0;
    model_active[cf] = 0;
    chk({tag, "_cnt"}, active_flow_cnt, model_cnt());
  endtask

  initial begin
    vecs[0] = '{4'd5,  16'd64,     8'd2, 8'd3, 4'd4,  0, 0, -1, 4'd0,  0};
    vecs[1] = '{4'd5,  16'd64,     8'd2, 8'd3, 4'd4,  0, 0, -1, 4'd0,  1};
    vecs[2] = '{4'd5,  16'd32,     8'd1, 8'd1, 4'd1,  0, 0,  1, 4'd5,  0};
    vecs[3] = '{4'd9,  16'd0,      8'd9, 8'd9, 4'd9,  0, 0, -1, 4'd0,  2};
    vecs[4] = '{4'd11, 16'd100,    8'd7, 8'd8, 4'd15, 3, 2, -1, 4'd0,  0};
    vecs[5] = '{4'd11, 16'd5,      8'd0, 8'd0, 4'd0,  0, 0,  1, 4'd4,  1};
    vecs[6] = '{4'd12, 16'd1,      8'd3, 8'd4, 4'd5,  0, 0,  3, 4'd11, 0};
    vecs[7] = '{4'd0,  16'hFFFF,   8'hFF, 8'h0, 4'd7, 1, 0,  4, 4'd0,  0};

    repeat (3) step();
    chk("reset_rdy", app_msg_req_rdy, 0);
    chk("reset_vals", {msg_req_resp_val, reg_msg_req_mem_wr_val, reg_msg_req_q_wr_val}, 0);
    chk("reset_cnt", active_flow_cnt, 0);
    chk("reset_data", {reg_msg_req_mem_wr_data, reg_msg_req_mem_wr_addr}, 0);
    rst = 1'b0;
    step(); step();
    chk("post_reset_rdy", app_msg_req_rdy, 1);

    foreach (vecs[i])
      run_req(vecs[i].f, vecs[i].len, vecs[i].x, vecs[i].y, vecs[i].fb, vecs[i].ms, vecs[i].qs,
              vecs[i].clr_cyc, vecs[i].cf, vecs[i].exp_st, $sformatf("vec%0d", i));
    chk("table_cnt", active_flow_cnt, 3);
    clear_pulse(4'd5, "clr_active");
    clear_pulse(4'd9, "clr_idle_bit");

    // Reset while the enqueue is stalled drops the request and empties the set
    run_req(4'd5, 16'd8, 8'd1, 8'd2, 4'd3, 0, 0, -1, 4'd0, -1, "pre_rst");
    for (int i = 0; i < 8 && !app_msg_req_rdy; i++) step();
    app_msg_req_val = 1'b1; app_msg_req_flowid = 4'd7; app_msg_req_len = 16'd10;
    step();
    app_msg_req_val = 1'b0; reg_msg_req_mem_wr_rdy = 1'b1; reg_msg_req_q_wr_rdy = 1'b0;
    for (int i = 0; i < 10 && !reg_msg_req_q_wr_val; i++) step();
    chk("rst_reached_wr_q", reg_msg_req_q_wr_val, 1);
    rst = 1'b1;
    step();
    chk("midrst_vals", {msg_req_resp_val, reg_msg_req_mem_wr_val, reg_msg_req_q_wr_val, app_msg_req_rdy}, 0);
    chk("midrst_cnt", active_flow_cnt, 0);
    chk("midrst_data", {reg_msg_req_mem_wr_data, reg_msg_req_q_wr_data, msg_req_resp_flowid, msg_req_resp_status}, 0);
    rst = 1'b0; reg_msg_req_mem_wr_rdy = 1'b0;
    foreach (model_active[i]) model_active[i] = 0;
    step();
    run_req(4'd5, 16'd20, 8'd4, 8'd4, 4'd2, 0, 0, -1, 4'd0, 0, "after_rst_f5");
    run_req(4'd7, 16'd10, 8'd0, 8'd0, 4'd0, 0, 0, -1, 4'd0, 0, "after_rst_f7");

    for (int n = 0; n < 60; n++) begin
      logic [FLOWID_W-1:0] rf = FLOWID_W'($urandom_range(0, 7));
      logic [15:0] rl = ($urandom % 5 == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      int rc = ($urandom % 3 == 0) ? -1 : int'($urandom_range(0, 4));
      logic [FLOWID_W-1:0] rcf = FLOWID_W'($urandom_range(0, 7));
      run_req(rf, rl, 8'($urandom), 8'($urandom), 4'($urandom), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), rc, rcf, -1, $sformatf("rnd%0d", n));
      if ($urandom % 4 == 0) clear_pulse(FLOWID_W'($urandom_range(0, 7)), $sformatf("rndclr%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
